counter_tick_gen: RTL and testbench

//  Upstream control stage for the up/down counter. Divides clk into a one-cycle tick strobe (clock enable).

---
 rtl/counter_tick_gen_pkg.sv | 13 +
 rtl/counter_tick_gen_if.sv | 31 +++
 rtl/counter_tick_gen_debounce.sv | 94 +++++++++
 rtl/counter_tick_gen.sv | 77 +++++++
 tb/tb_counter_tick_gen.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/counter_tick_gen_pkg.sv
// Shared types and constants for the counter tick/mode control stage.
package counter_tick_pkg;

  typedef enum logic [1:0] {
    S_STABLE,
    S_CHECK,
    S_PENDING
  } deb_state_t;

  localparam logic MODE_UP   = 1'b1;
  localparam logic MODE_DOWN = 1'b0;

endpackage

// File: rtl/counter_tick_gen_if.sv
// Control/status bundle between the counter tick generator and its user.
// clk_d exists only when CLK_D_OUT_EN is defined.
interface counter_tick_gen_if #(
  parameter int unsigned DIV_W = 8
);
  logic             en;
  logic [DIV_W-1:0] div_ratio;
  logic             mode_raw;
  logic             tick;
  logic             mode;
  logic             dir_chg;
`ifdef CLK_D_OUT_EN
  logic             clk_d;
`endif

  modport master (
    output en, div_ratio, mode_raw,
`ifdef CLK_D_OUT_EN
    input  clk_d,
`endif
    input  tick, mode, dir_chg
  );

  modport slave (
    input  en, div_ratio, mode_raw,
`ifdef CLK_D_OUT_EN
    output clk_d,
`endif
    output tick, mode, dir_chg
  );
endinterface

// File: rtl/counter_tick_gen_debounce.sv
// Direction-request debouncer: a new mode_raw level must persist DEB_CYC sampled
// cycles, then waits in S_PENDING until the top signals the edge that raises tick.
module mode_debounce
  import counter_tick_pkg::*;
#(
  parameter int unsigned DEB_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic mode_raw,
  input  logic tick,
  input  logic mode,
  output logic mode_nxt,
  output logic apply
);

  localparam int unsigned CW = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYC - 1);

  deb_state_t    state, state_n;
  logic [CW-1:0] deb_cnt, cnt_n;
  logic          pend_dir, pend_n;
  logic          differ;

  assign differ   = (mode_raw != mode);
  assign mode_nxt = pend_dir;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_STABLE;
      deb_cnt  <= '0;
      pend_dir <= MODE_UP;
    end else begin
      state    <= state_n;
      deb_cnt  <= cnt_n;
      pend_dir <= pend_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = deb_cnt;
    pend_n  = pend_dir;
    apply   = 1'b0;
    case (state)
      S_STABLE: begin
        if (differ) begin
          pend_n = mode_raw;
          if (DEB_CYC <= 1) begin
            state_n = S_PENDING;
            cnt_n   = '0;
          end else begin
            state_n = S_CHECK;
            cnt_n   = CW'(1);
          end
        end
      end
      S_CHECK: begin
        if (!differ) begin
          state_n = S_STABLE;
          cnt_n   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_n = S_PENDING;
          pend_n  = mode_raw;
          cnt_n   = '0;
        end else begin
          cnt_n = deb_cnt + CW'(1);
        end
      end
      S_PENDING: begin
        // Tick wins over cancellation; while pending, deb_cnt counts reverted cycles.
        if (tick) begin
          apply   = 1'b1;
          state_n = S_STABLE;
          cnt_n   = '0;
        end else if (!differ) begin
          if (deb_cnt == DEB_LAST) begin
            state_n = S_STABLE;
            cnt_n   = '0;
          end else begin
            cnt_n = deb_cnt + CW'(1);
          end
        end else begin
          cnt_n = '0;
        end
      end
      default: begin
        state_n = S_STABLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: rtl/counter_tick_gen.sv
// Clock divider producing a one-cycle tick plus a debounced mode applied only on tick.
// Define CLK_D_OUT_EN to add the clk_d debug output (toggles on every tick).
module counter_tick_gen
  import counter_tick_pkg::*;
#(
  parameter int unsigned DIV_W    = 8,
  parameter int unsigned DEB_CYC  = 4,
  parameter logic        MODE_RST = MODE_UP
) (
  input logic               clk,
  input logic               rst,
  counter_tick_gen_if.slave bus
);

  logic [DIV_W-1:0] div_cnt, ratio_q, ratio_eff;
  logic             load_pend;
  logic             wrap;
  logic             tick_q, mode_q, dir_chg_q;
  logic             mode_nxt, apply;

  // The first period after reset must already use div_ratio, before ratio_q is loaded.
  assign ratio_eff = load_pend ? bus.div_ratio : ratio_q;
  assign wrap      = bus.en && (div_cnt == ratio_eff);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt   <= '0;
      ratio_q   <= '0;
      load_pend <= 1'b1;
      tick_q    <= 1'b0;
      dir_chg_q <= 1'b0;
      mode_q    <= MODE_RST;
    end else begin
      load_pend <= 1'b0;
      if (load_pend || wrap)
        ratio_q <= bus.div_ratio;
      if (wrap)
        div_cnt <= '0;
      else if (bus.en)
        div_cnt <= div_cnt + 1'b1;
      tick_q    <= wrap;
      dir_chg_q <= apply;
      if (apply)
        mode_q <= mode_nxt;
    end
  end

  mode_debounce #(
    .DEB_CYC(DEB_CYC)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .mode_raw (bus.mode_raw),
    .tick     (wrap),
    .mode     (mode_q),
    .mode_nxt (mode_nxt),
    .apply    (apply)
  );

  assign bus.tick    = tick_q;
  assign bus.mode    = mode_q;
  assign bus.dir_chg = dir_chg_q;

`ifdef CLK_D_OUT_EN
  logic clk_d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      clk_d_q <= 1'b0;
    else if (wrap)
      clk_d_q <= ~clk_d_q;
  end

  assign bus.clk_d = clk_d_q;
`endif

endmodule

// File: tb/tb_counter_tick_gen.sv
// Directed bench for counter_tick_gen (DIV_W=8, DEB_CYC=4, MODE_RST=1).
module tb_counter_tick_gen;

  logic clk;
  logic rst;
  int   vec;
  int   errs;

  counter_tick_gen_if #(.DIV_W(8)) bus ();

  counter_tick_gen #(
    .DIV_W    (8),
    .DEB_CYC  (4),
    .MODE_RST (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.en = 1'b0; bus.div_ratio = 8'd0; bus.mode_raw = 1'b1;
    cyc();
    cyc();
    vec++; if (bus.tick !== 1'b0) begin errs++; $display("FAIL reset_tick got %b exp 0", bus.tick); end
    vec++; if (bus.mode !== 1'b1) begin errs++; $display("FAIL reset_mode got %b exp 1", bus.mode); end
    vec++; if (bus.dir_chg !== 1'b0) begin errs++; $display("FAIL reset_dir_chg got %b exp 0", bus.dir_chg); end
`ifdef CLK_D_OUT_EN
    vec++; if (bus.clk_d !== 1'b0) begin errs++; $display("FAIL reset_clk_d got %b exp 0", bus.clk_d); end
`endif
    rst = 1'b0;
    bus.en = 1'b1;
    cyc();
    vec++; if (bus.tick !== 1'b1) begin errs++; $display("FAIL ratio0_first_tick got %b exp 1", bus.tick); end
    #3;
    rst = 1'b1;
    #1;
    vec++; if (bus.tick !== 1'b0) begin errs++; $display("FAIL async_reset_tick got %b exp 0", bus.tick); end
`ifdef CLK_D_OUT_EN
    vec++; if (bus.clk_d !== 1'b0) begin errs++; $display("FAIL async_reset_clk_d got %b exp 0", bus.clk_d); end
`endif
    cyc();
    rst = 1'b0;
    bus.en = 1'b0;
  endtask

  task automatic test_divide();
    logic e;
    do_reset();
    bus.div_ratio = 8'd3; bus.en = 1'b1; bus.mode_raw = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      e = (k <= 12) ? (k % 4 == 0) : (k >= 16);
      vec++; if (bus.tick !== e) begin errs++; $display("FAIL divide_tick k=%0d got %b exp %b", k, bus.tick, e); end
      if (k == 12) bus.div_ratio = 8'd0;
    end
    bus.en = 1'b0;
  endtask

  task automatic test_direction();
    logic et, em, ed;
    do_reset();
    bus.div_ratio = 8'd4; bus.en = 1'b1; bus.mode_raw = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      cyc();
      et = (k % 5 == 0);
      em = (k < 10) ? 1'b1 : (k < 20) ? 1'b0 : 1'b1;
      ed = (k == 10) || (k == 20);
      vec++; if (bus.tick !== et) begin errs++; $display("FAIL dir_tick k=%0d got %b exp %b", k, bus.tick, et); end
      vec++; if (bus.mode !== em) begin errs++; $display("FAIL dir_mode k=%0d got %b exp %b", k, bus.mode, em); end
      vec++; if (bus.dir_chg !== ed) begin errs++; $display("FAIL dir_chg k=%0d got %b exp %b", k, bus.dir_chg, ed); end
      if (k == 1)  bus.mode_raw = 1'b0;
      if (k == 11) bus.mode_raw = 1'b1;
    end
  endtask

  task automatic test_bounce();
    do_reset();
    bus.div_ratio = 8'd2; bus.en = 1'b1; bus.mode_raw = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      vec++; if (bus.mode !== 1'b1) begin errs++; $display("FAIL bounce_mode k=%0d got %b exp 1", k, bus.mode); end
      vec++; if (bus.dir_chg !== 1'b0) begin errs++; $display("FAIL bounce_dir_chg k=%0d got %b exp 0", k, bus.dir_chg); end
      if (k == 1) bus.mode_raw = 1'b0;
      if (k == 3) bus.mode_raw = 1'b1;
    end
    // Accepted change reverts for 4 cycles before its tick: cancelled.
    do_reset();
    bus.div_ratio = 8'd15;
    for (int k = 1; k <= 18; k++) begin
      cyc();
      vec++; if (bus.tick !== (k == 16)) begin errs++; $display("FAIL cancel_tick k=%0d got %b exp %b", k, bus.tick, k == 16); end
      vec++; if (bus.mode !== 1'b1) begin errs++; $display("FAIL cancel_mode k=%0d got %b exp 1", k, bus.mode); end
      vec++; if (bus.dir_chg !== 1'b0) begin errs++; $display("FAIL cancel_dir_chg k=%0d got %b exp 0", k, bus.dir_chg); end
      if (k == 1) bus.mode_raw = 1'b0;
      if (k == 5) bus.mode_raw = 1'b1;
    end
  endtask

  task automatic test_hold();
    logic e;
    do_reset();
    bus.div_ratio = 8'd3; bus.en = 1'b1; bus.mode_raw = 1'b1;
    for (int k = 1; k <= 28; k++) begin
      cyc();
      e = (k == 4) || (k == 15) || (k == 19) || (k == 27);
      vec++; if (bus.tick !== e) begin errs++; $display("FAIL hold_tick k=%0d got %b exp %b", k, bus.tick, e); end
      if (k == 5)  bus.en = 1'b0;
      if (k == 12) bus.en = 1'b1;
      if (k == 16) bus.div_ratio = 8'd7;
    end
  endtask

  task automatic test_reset_pending();
    logic em;
    do_reset();
    bus.div_ratio = 8'd1; bus.en = 1'b1; bus.mode_raw = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      cyc();
      em = (k < 6);
      vec++; if (bus.mode !== em) begin errs++; $display("FAIL pend_mode k=%0d got %b exp %b", k, bus.mode, em); end
      vec++; if (bus.dir_chg !== (k == 6)) begin errs++; $display("FAIL pend_dir_chg k=%0d got %b exp %b", k, bus.dir_chg, k == 6); end
      if (k == 1) bus.mode_raw = 1'b0;
      if (k == 6) bus.mode_raw = 1'b1;
    end
    #3;
    rst = 1'b1;
    #1;
    vec++; if (bus.mode !== 1'b1) begin errs++; $display("FAIL pend_rst_mode got %b exp 1", bus.mode); end
    vec++; if (bus.dir_chg !== 1'b0) begin errs++; $display("FAIL pend_rst_dir_chg got %b exp 0", bus.dir_chg); end
    cyc();
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      vec++; if (bus.mode !== 1'b1) begin errs++; $display("FAIL post_rst_mode k=%0d got %b exp 1", k, bus.mode); end
      vec++; if (bus.dir_chg !== 1'b0) begin errs++; $display("FAIL post_rst_dir_chg k=%0d got %b exp 0", k, bus.dir_chg); end
      vec++; if (bus.tick !== (k % 2 == 0)) begin errs++; $display("FAIL post_rst_tick k=%0d got %b exp %b", k, bus.tick, k % 2 == 0); end
`ifdef CLK_D_OUT_EN
      vec++; if (bus.clk_d !== 1'((k / 2) & 1)) begin errs++; $display("FAIL clk_d k=%0d got %b exp %b", k, bus.clk_d, 1'((k / 2) & 1)); end
`endif
    end
  endtask

  initial begin
    vec  = 0;
    errs = 0;
    test_reset();
    test_divide();
    test_direction();
    test_bounce();
    test_hold();
    test_reset_pending();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
